// File: rtl/fpu_issue_ctrl.sv
// In-order issue/retire controller for a tagged FPU: tags commands, reorders results, sequences flushes.
// Optional status accumulator enabled by defining FPU_ISSUE_STATUS_ACC_EN.
`timescale 1ns/1ps

module fpu_issue_ctrl #(
    parameter int FLEN      = 32,
    parameter int TAG_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [3*FLEN-1:0]    cmd_operands_i,
    input  logic [3:0]           cmd_op_i,
    input  logic                 cmd_op_mod_i,
    input  logic [2:0]           cmd_rnd_i,
    input  logic                 flush_i,
    output logic                 fpu_in_valid_o,
    input  logic                 fpu_in_ready_i,
    output logic [3*FLEN-1:0]    fpu_operands_o,
    output logic [3:0]           fpu_op_o,
    output logic                 fpu_op_mod_o,
    output logic [2:0]           fpu_rnd_o,
    output logic [TAG_WIDTH-1:0] fpu_tag_o,
    output logic                 fpu_flush_o,
    input  logic                 fpu_out_valid_i,
    output logic                 fpu_out_ready_o,
    input  logic [FLEN-1:0]      fpu_result_i,
    input  logic [4:0]           fpu_status_i,
    input  logic [TAG_WIDTH-1:0] fpu_tag_i,
    input  logic                 fpu_busy_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [FLEN-1:0]      rsp_result_o,
    output logic [4:0]           rsp_status_o,
    output logic [4:0]           status_acc_o,
    input  logic                 status_clr_i,
    output logic                 busy_o
);

    localparam int DEPTH = 2**TAG_WIDTH;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t               state;
    logic [DEPTH-1:0]     pending;
    logic [DEPTH-1:0]     done;
    logic [TAG_WIDTH-1:0] issue_ptr;
    logic [TAG_WIDTH-1:0] retire_ptr;
    logic [FLEN-1:0]      result_mem [DEPTH];
    logic [4:0]           status_mem [DEPTH];

    logic run;
    logic slot_free;
    logic issue_fire;
    logic cpl_fire;
    logic rsp_fire;

    // Free-slot test uses registered state only, so a same-cycle retire never unblocks a full ring.
    assign run       = (state == RUN);
    assign slot_free = !pending[issue_ptr] && !done[issue_ptr];

    assign fpu_in_valid_o = run && cmd_valid_i && slot_free && !flush_i;
    assign cmd_ready_o    = run && fpu_in_ready_i && slot_free && !flush_i;
    assign fpu_operands_o = cmd_operands_i;
    assign fpu_op_o       = cmd_op_i;
    assign fpu_op_mod_o   = cmd_op_mod_i;
    assign fpu_rnd_o      = cmd_rnd_i;
    assign fpu_tag_o      = issue_ptr;
    assign fpu_flush_o    = flush_i;

    assign fpu_out_ready_o = 1'b1;

    assign rsp_valid_o  = run && done[retire_ptr];
    assign rsp_result_o = result_mem[retire_ptr];
    assign rsp_status_o = status_mem[retire_ptr];

    assign busy_o = (|pending) || (|done) || (state == FLUSH);

    assign issue_fire = fpu_in_valid_o && fpu_in_ready_i;
    assign cpl_fire   = run && !flush_i && fpu_out_valid_i && pending[fpu_tag_i];
    assign rsp_fire   = rsp_valid_o && rsp_ready_i && !flush_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= RUN;
            pending    <= '0;
            done       <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
        end else if (flush_i) begin
            state      <= FLUSH;
            pending    <= '0;
            done       <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
        end else if (state == FLUSH) begin
            if (!fpu_busy_i && !fpu_out_valid_i) begin
                state <= RUN;
            end
        end else begin
            // Issue, completion and retire touch disjoint slots, so all three may land together.
            if (issue_fire) begin
                pending[issue_ptr] <= 1'b1;
                issue_ptr          <= issue_ptr + TAG_WIDTH'(1);
            end
            if (cpl_fire) begin
                pending[fpu_tag_i] <= 1'b0;
                done[fpu_tag_i]    <= 1'b1;
            end
            if (rsp_fire) begin
                done[retire_ptr] <= 1'b0;
                retire_ptr       <= retire_ptr + TAG_WIDTH'(1);
            end
        end
    end

    // NOTE: payload storage has no reset; the done bits alone say which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (cpl_fire) begin
            result_mem[fpu_tag_i] <= fpu_result_i;
            status_mem[fpu_tag_i] <= fpu_status_i;
        end
    end

`ifdef FPU_ISSUE_STATUS_ACC_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_acc_o <= '0;
        end else if (status_clr_i) begin
            status_acc_o <= '0;
        end else if (rsp_fire) begin
            status_acc_o <= status_acc_o | rsp_status_o;
        end
    end
`else
    logic unused_status_clr;
    assign unused_status_clr = status_clr_i;
    assign status_acc_o      = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus a randomized run against a
// queue-based in-order scoreboard and an out-of-order FPU model.
`timescale 1ns/1ps

module tb_fpu_issue_ctrl;

    localparam int FLEN  = 32;
    localparam int TW    = 2;
    localparam int DEPTH = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              cmd_valid_i, cmd_ready_o;
    logic [3*FLEN-1:0] cmd_operands_i;
    logic [3:0]        cmd_op_i;
    logic              cmd_op_mod_i;
    logic [2:0]        cmd_rnd_i;
    logic              flush_i;
    logic              fpu_in_valid_o, fpu_in_ready_i;
    logic [3*FLEN-1:0] fpu_operands_o;
    logic [3:0]        fpu_op_o;
    logic              fpu_op_mod_o;
    logic [2:0]        fpu_rnd_o;
    logic [TW-1:0]     fpu_tag_o;
    logic              fpu_flush_o;
    logic              fpu_out_valid_i, fpu_out_ready_o;
    logic [FLEN-1:0]   fpu_result_i;
    logic [4:0]        fpu_status_i;
    logic [TW-1:0]     fpu_tag_i;
    logic              fpu_busy_i;
    logic              rsp_valid_o, rsp_ready_i;
    logic [FLEN-1:0]   rsp_result_o;
    logic [4:0]        rsp_status_o;
    logic [4:0]        status_acc_o;
    logic              status_clr_i;
    logic              busy_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [TW-1:0]   tag;
        logic [FLEN-1:0] res;
        logic [4:0]      st;
        bit              completed;
    } op_t;

    fpu_issue_ctrl #(.FLEN(FLEN), .TAG_WIDTH(TW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_operands_i(cmd_operands_i), .cmd_op_i(cmd_op_i),
        .cmd_op_mod_i(cmd_op_mod_i), .cmd_rnd_i(cmd_rnd_i),
        .flush_i(flush_i),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
        .fpu_op_mod_o(fpu_op_mod_o), .fpu_rnd_o(fpu_rnd_o), .fpu_tag_o(fpu_tag_o),
        .fpu_flush_o(fpu_flush_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .fpu_busy_i(fpu_busy_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
        .status_acc_o(status_acc_o), .status_clr_i(status_clr_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid_i = 1'b0; cmd_operands_i = '0; cmd_op_i = '0; cmd_op_mod_i = 1'b0; cmd_rnd_i = '0;
        flush_i = 1'b0; fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0; fpu_result_i = '0;
        fpu_status_i = '0; fpu_tag_i = '0; fpu_busy_i = 1'b0; rsp_ready_i = 1'b0; status_clr_i = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Issues one command, completes it the next cycle with status st, then retires it.
    task automatic run_op(input logic [4:0] st, input logic clr);
        logic [TW-1:0] t;
        cmd_valid_i = 1'b1; fpu_in_ready_i = 1'b1;
        #1;
        t = fpu_tag_o;
        tick();
        cmd_valid_i = 1'b0;
        fpu_out_valid_i = 1'b1; fpu_tag_i = t; fpu_result_i = $urandom; fpu_status_i = st;
        tick();
        fpu_out_valid_i = 1'b0;
        rsp_ready_i = 1'b1; status_clr_i = clr;
        #1;
        checks++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== st) begin failures++; $display("FAIL run_op_rsp: valid=%b status=%h expected valid=1 status=%h", rsp_valid_o, rsp_status_o, st); end
        tick();
        rsp_ready_i = 1'b0; status_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
        checks++; if (fpu_flush_o !== 1'b0) begin failures++; $display("FAIL reset_fpu_flush: got %b expected 0", fpu_flush_o); end
        checks++; if (status_acc_o !== 5'h00) begin failures++; $display("FAIL reset_status_acc: got %h expected 00", status_acc_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready_o); end
        checks++; if (fpu_out_ready_o !== 1'b1) begin failures++; $display("FAIL reset_out_ready: got %b expected 1", fpu_out_ready_o); end
        fpu_in_ready_i = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready_after: got %b expected 1", cmd_ready_o); end
        checks++; if (fpu_tag_o !== 2'd0) begin failures++; $display("FAIL reset_tag: got %0d expected 0", fpu_tag_o); end
    endtask

    task automatic test_single_op();
        apply_reset();
        cmd_operands_i = {32'h0, 32'h40000000, 32'h3F800000};
        cmd_valid_i = 1'b1; fpu_in_ready_i = 1'b1;
        #1;
        checks++; if (fpu_in_valid_o !== 1'b1 || cmd_ready_o !== 1'b1) begin failures++; $display("FAIL single_issue: valid=%b ready=%b expected 1 1", fpu_in_valid_o, cmd_ready_o); end
        checks++; if (fpu_tag_o !== 2'd0) begin failures++; $display("FAIL single_tag: got %0d expected 0", fpu_tag_o); end
        checks++; if (fpu_operands_o !== {32'h0, 32'h40000000, 32'h3F800000}) begin failures++; $display("FAIL single_operands: got %h", fpu_operands_o); end
        tick();
        cmd_valid_i = 1'b0;
        tick();
        fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = 32'h40400000; fpu_status_i = 5'h00;
        #1;
        checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL single_no_bypass: got %b expected 0", rsp_valid_o); end
        tick();
        fpu_out_valid_i = 1'b0;
        #1;
        checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid_o); end
        checks++; if (rsp_result_o !== 32'h40400000 || rsp_status_o !== 5'h00) begin failures++; $display("FAIL single_rsp_data: got %h/%h expected 40400000/00", rsp_result_o, rsp_status_o); end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        #1;
        checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL single_drained: rsp_valid=%b busy=%b expected 0 0", rsp_valid_o, busy_o); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        fpu_in_ready_i = 1'b1; cmd_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_operands_i = {3{32'(i)}};
            #1;
            checks++; if (cmd_ready_o !== 1'b1 || fpu_tag_o !== TW'(i)) begin failures++; $display("FAIL b2b_issue%0d: ready=%b tag=%0d expected 1 %0d", i, cmd_ready_o, fpu_tag_o, i); end
            tick();
        end
        #1;
        checks++; if (cmd_ready_o !== 1'b0 || fpu_in_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_full: ready=%b valid=%b expected 0 0", cmd_ready_o, fpu_in_valid_o); end
        fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = 32'h000000A0;
        tick();
        fpu_out_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        #1;
        checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_head_valid: got %b expected 1", rsp_valid_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_full_retire: got %b expected 0", cmd_ready_o); end
        tick();
        rsp_ready_i = 1'b0;
        #1;
        checks++; if (cmd_ready_o !== 1'b1 || fpu_tag_o !== 2'd0) begin failures++; $display("FAIL b2b_after_retire: ready=%b tag=%0d expected 1 0", cmd_ready_o, fpu_tag_o); end
        tick();
        cmd_valid_i = 1'b0;
        #1;
        checks++; if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL b2b_refull: ready=%b busy=%b expected 0 1", cmd_ready_o, busy_o); end
    endtask

    task automatic test_reorder();
        logic [FLEN-1:0] r [4];
        int order [4] = '{2, 0, 3, 1};
        int k = 0;
        int nret = 0;
        apply_reset();
        fpu_in_ready_i = 1'b1; cmd_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r[i] = $urandom;
            tick();
        end
        cmd_valid_i = 1'b0;
        for (int cyc = 0; cyc < 64 && nret < 4; cyc++) begin
            if (k < 4) begin
                fpu_out_valid_i = 1'b1; fpu_tag_i = TW'(order[k]);
                fpu_result_i = r[order[k]]; fpu_status_i = 5'(order[k]);
                k++;
            end else begin
                fpu_out_valid_i = 1'b0;
            end
            rsp_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (rsp_valid_o === 1'b1 && rsp_ready_i) begin
                checks++; if (rsp_result_o !== r[nret] || rsp_status_o !== 5'(nret)) begin failures++; $display("FAIL reorder_rsp%0d: got %h/%h expected %h/%h", nret, rsp_result_o, rsp_status_o, r[nret], 5'(nret)); end
                nret++;
            end
            tick();
        end
        fpu_out_valid_i = 1'b0; rsp_ready_i = 1'b0;
        #1;
        checks++; if (nret != 4) begin failures++; $display("FAIL reorder_count: got %0d responses expected 4", nret); end
        checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL reorder_empty: rsp_valid=%b busy=%b expected 0 0", rsp_valid_o, busy_o); end
    endtask

    task automatic test_flush();
        apply_reset();
        fpu_in_ready_i = 1'b1; cmd_valid_i = 1'b1;
        repeat (3) tick();
        flush_i = 1'b1; fpu_busy_i = 1'b1;
        fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = 32'hDEAD0000;
        #1;
        checks++; if (fpu_flush_o !== 1'b1) begin failures++; $display("FAIL flush_pulse: got %b expected 1", fpu_flush_o); end
        checks++; if (cmd_ready_o !== 1'b0 || fpu_in_valid_o !== 1'b0) begin failures++; $display("FAIL flush_no_issue: ready=%b valid=%b expected 0 0", cmd_ready_o, fpu_in_valid_o); end
        tick();
        flush_i = 1'b0; fpu_tag_i = 2'd1; fpu_result_i = 32'hDEAD0001;
        #1;
        checks++; if (fpu_flush_o !== 1'b0) begin failures++; $display("FAIL flush_one_cycle: got %b expected 0", fpu_flush_o); end
        checks++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL flush_hold: rsp=%b ready=%b busy=%b expected 0 0 1", rsp_valid_o, cmd_ready_o, busy_o); end
        tick();
        fpu_out_valid_i = 1'b0; flush_i = 1'b1;
        #1;
        checks++; if (fpu_flush_o !== 1'b1) begin failures++; $display("FAIL flush_repulse: got %b expected 1", fpu_flush_o); end
        tick();
        flush_i = 1'b0; fpu_busy_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin failures++; $display("FAIL flush_wait: busy=%b ready=%b rsp=%b expected 1 0 0", busy_o, cmd_ready_o, rsp_valid_o); end
        tick();
        #1;
        checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin failures++; $display("FAIL flush_run_idle: busy=%b rsp=%b expected 0 0", busy_o, rsp_valid_o); end
        checks++; if (cmd_ready_o !== 1'b1 || fpu_tag_o !== 2'd0) begin failures++; $display("FAIL flush_next_tag: ready=%b tag=%0d expected 1 0", cmd_ready_o, fpu_tag_o); end
        tick();
        cmd_valid_i = 1'b0;
        fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = 32'h00001234; fpu_status_i = 5'h02;
        tick();
        fpu_out_valid_i = 1'b0;
        #1;
        checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h00001234) begin failures++; $display("FAIL flush_post_rsp: valid=%b result=%h expected 1 00001234", rsp_valid_o, rsp_result_o); end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_status();
        apply_reset();
`ifdef FPU_ISSUE_STATUS_ACC_EN
        run_op(5'h01, 1'b0);
        #1;
        checks++; if (status_acc_o !== 5'h01) begin failures++; $display("FAIL status_first: got %h expected 01", status_acc_o); end
        run_op(5'h10, 1'b0);
        #1;
        checks++; if (status_acc_o !== 5'h11) begin failures++; $display("FAIL status_or: got %h expected 11", status_acc_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        #1;
        checks++; if (status_acc_o !== 5'h11) begin failures++; $display("FAIL status_flush_keep: got %h expected 11", status_acc_o); end
        run_op(5'h04, 1'b1);
        #1;
        checks++; if (status_acc_o !== 5'h00) begin failures++; $display("FAIL status_clear_wins: got %h expected 00", status_acc_o); end
`else
        run_op(5'h1F, 1'b0);
        #1;
        checks++; if (status_acc_o !== 5'h00) begin failures++; $display("FAIL status_tied: got %h expected 00", status_acc_o); end
        run_op(5'h15, 1'b1);
        #1;
        checks++; if (status_acc_o !== 5'h00) begin failures++; $display("FAIL status_tied_clr: got %h expected 00", status_acc_o); end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fpu_in_ready_i = 1'b1; cmd_valid_i = 1'b1;
        repeat (2) tick();
        cmd_valid_i = 1'b0; fpu_in_ready_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL midreset_pre_busy: got %b expected 1", busy_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || fpu_flush_o !== 1'b0) begin failures++; $display("FAIL midreset_outs: busy=%b rsp=%b flush=%b expected 0 0 0", busy_o, rsp_valid_o, fpu_flush_o); end
        checks++; if (status_acc_o !== 5'h00 || cmd_ready_o !== 1'b0 || fpu_in_valid_o !== 1'b0) begin failures++; $display("FAIL midreset_outs2: acc=%h ready=%b valid=%b expected 00 0 0", status_acc_o, cmd_ready_o, fpu_in_valid_o); end
        tick();
        rst_ni = 1'b1; cmd_valid_i = 1'b1; fpu_in_ready_i = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b1 || fpu_tag_o !== 2'd0) begin failures++; $display("FAIL midreset_next_tag: ready=%b tag=%0d expected 1 0", cmd_ready_o, fpu_tag_o); end
        tick();
        cmd_valid_i = 1'b0;
    endtask

    // Scoreboard: rob_q holds issued ops in issue order; fpu_q holds ops the fake FPU still owes.
    task automatic test_random(input int n);
        op_t rob_q [$];
        op_t fpu_q [$];
        op_t o;
        int issued = 0;
        int pick;
        int stray_tag;
        bit exp_rdy, exp_fire, exp_rsp, free_tag;
        logic [4:0] acc_m = 5'h00;
        apply_reset();
        for (int cyc = 0; cyc < n; cyc++) begin
            cmd_valid_i    = 1'($urandom_range(0, 1));
            cmd_operands_i = {$urandom, $urandom, $urandom};
            cmd_op_i = 4'($urandom); cmd_op_mod_i = 1'($urandom); cmd_rnd_i = 3'($urandom);
            fpu_in_ready_i = ($urandom_range(0, 3) != 0);
            rsp_ready_i    = 1'($urandom_range(0, 1));
            pick = -1;
            fpu_out_valid_i = 1'b0; fpu_tag_i = TW'($urandom); fpu_result_i = $urandom; fpu_status_i = 5'($urandom);
            if (fpu_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, fpu_q.size() - 1);
                fpu_out_valid_i = 1'b1; fpu_tag_i = fpu_q[pick].tag;
                fpu_result_i = fpu_q[pick].res; fpu_status_i = fpu_q[pick].st;
            end else if ($urandom_range(0, 3) == 0) begin
                stray_tag = $urandom_range(0, DEPTH - 1);
                free_tag = 1'b1;
                for (int j = 0; j < fpu_q.size(); j++) if (int'(fpu_q[j].tag) == stray_tag) free_tag = 1'b0;
                if (free_tag) begin
                    fpu_out_valid_i = 1'b1; fpu_tag_i = TW'(stray_tag);
                end
            end
            #1;
            exp_rdy  = fpu_in_ready_i && (rob_q.size() < DEPTH);
            exp_fire = cmd_valid_i && exp_rdy;
            exp_rsp  = 1'b0;
            if (rob_q.size() > 0) exp_rsp = rob_q[0].completed;
            checks++; if (cmd_ready_o !== exp_rdy) begin failures++; $display("FAIL rand_cmd_ready c%0d: got %b expected %b", cyc, cmd_ready_o, exp_rdy); end
            checks++; if (fpu_in_valid_o !== (cmd_valid_i && rob_q.size() < DEPTH)) begin failures++; $display("FAIL rand_in_valid c%0d: got %b", cyc, fpu_in_valid_o); end
            if (exp_fire) begin
                checks++; if (fpu_tag_o !== TW'(issued % DEPTH)) begin failures++; $display("FAIL rand_tag c%0d: got %0d expected %0d", cyc, fpu_tag_o, issued % DEPTH); end
                checks++; if ({fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_o} !== {cmd_operands_i, cmd_op_i, cmd_op_mod_i, cmd_rnd_i}) begin failures++; $display("FAIL rand_fields c%0d: got %h expected %h", cyc, {fpu_operands_o, fpu_op_o}, {cmd_operands_i, cmd_op_i}); end
            end
            checks++; if (rsp_valid_o !== exp_rsp) begin failures++; $display("FAIL rand_rsp_valid c%0d: got %b expected %b", cyc, rsp_valid_o, exp_rsp); end
            if (exp_rsp) begin
                checks++; if (rsp_result_o !== rob_q[0].res || rsp_status_o !== rob_q[0].st) begin failures++; $display("FAIL rand_rsp_data c%0d: got %h/%h expected %h/%h", cyc, rsp_result_o, rsp_status_o, rob_q[0].res, rob_q[0].st); end
            end
            checks++; if (busy_o !== (rob_q.size() > 0)) begin failures++; $display("FAIL rand_busy c%0d: got %b expected %b", cyc, busy_o, rob_q.size() > 0); end
            checks++; if (status_acc_o !== acc_m) begin failures++; $display("FAIL rand_status_acc c%0d: got %h expected %h", cyc, status_acc_o, acc_m); end
            if (pick >= 0) begin
                for (int j = 0; j < rob_q.size(); j++) begin
                    if (!rob_q[j].completed && rob_q[j].tag == fpu_q[pick].tag) rob_q[j].completed = 1'b1;
                end
                fpu_q.delete(pick);
            end
            if (exp_rsp && rsp_ready_i) begin
`ifdef FPU_ISSUE_STATUS_ACC_EN
                acc_m = acc_m | rob_q[0].st;
`endif
                rob_q.delete(0);
            end
            if (exp_fire) begin
                o.tag = TW'(issued % DEPTH); o.res = $urandom; o.st = 5'($urandom); o.completed = 1'b0;
                rob_q.push_back(o);
                fpu_q.push_back(o);
                issued++;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_op();
        test_back_to_back();
        test_reorder();
        test_flush();
        test_status();
        test_reset_mid();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
